cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//   Run-control sequencer for the single-cycle CPU. It decides each cycle whether the
//   current instruction commits: it gates the PC update and the register/memory write
//   strobes from the instruction decoder. It provides start/stop/single-step control,
//   honours the HALT opcode, and keeps cycle and retired-instruction counters.
// PARAMETERS
//   PC_W   8   PC/instruction-address width
//   CNT_W  16  width of cycle_cnt and instr_cnt
// PORTS
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      1-cycle pulse: begin free-running execution
//   step       in   1      1-cycle pulse: execute exactly one instruction
//   stop       in   1      1-cycle pulse: stop free-running execution
//   clear      in   1      leave HALT and zero both counters
//   halt_op    in   1      decoder halt (current opcode is HALT)
//   pc         in   PC_W   address of the current instruction
//   bp_addr    in   PC_W   breakpoint address
//   bp_valid   in   1      breakpoint armed
//   pc_en      out  1      PC register load enable (commit)
//   wr_en      out  1      ANDed with regwrite/memwrite in datapath; equals pc_en
//   state      out  2      00 IDLE, 01 RUN, 10 STEP, 11 HALT
//   bp_hit     out  1      sticky: stopped on breakpoint
//   cycle_cnt  out  CNT_W  cycles spent in RUN or STEP
//   instr_cnt  out  CNT_W  committed instructions
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, bp_hit=0, cycle_cnt=0, instr_cnt=0.
//     pc_en=wr_en=0 while in reset.
//   Control-input priority when several are sampled together: clear > stop > start > step.
//   pc_en is combinational from the registered state and the current inputs:
//     RUN:  pc_en = ~halt_op & ~stop & ~bp_stop
//     STEP: pc_en = ~halt_op
//     IDLE, HALT: pc_en = 0
//   wr_en == pc_en in every cycle. No write ever occurs in an uncommitted cycle.
//   Transitions (evaluated at rising edge):
//     IDLE: start -> RUN; step -> STEP; otherwise stay.
//     RUN:  halt_op -> HALT; stop -> IDLE; bp_stop -> IDLE; otherwise stay.
//     STEP: halt_op -> HALT; otherwise -> IDLE. STEP always lasts exactly 1 cycle.
//     HALT: clear -> IDLE; start/step/stop ignored.
//     clear in any state: -> IDLE, counters zeroed, bp_hit=0.
//       A clear sampled in RUN/STEP also forces pc_en=0 in that cycle.
//   halt_op together with stop in RUN: HALT wins; no commit.
//   Counters: each saturates at all-ones (no wrap).
//     cycle_cnt +1 every cycle with state RUN or STEP.
//     instr_cnt +1 every cycle with pc_en=1.
//   Counters hold their values in IDLE; only clear or reset zero them.
//   bp_stop is an internal signal. It is 0 unless the breakpoint feature is compiled in.
// CONFIGURATION
//   RUN_CTRL_BREAKPOINT_EN defined:
//     bp_stop = bp_valid & (pc==bp_addr) & ~skip_bp.
//     skip_bp is a flop set on every entry to RUN and cleared after the first RUN
//       cycle, so a resume from a breakpoint PC commits that instruction.
//     bp_stop sets bp_hit (registered).
//     bp_hit is cleared on start, step or clear; it is also cleared by reset.
//   RUN_CTRL_BREAKPOINT_EN undefined: bp_addr and bp_valid are ignored,
//     bp_stop=0, bp_hit tied 0, and no skip_bp flop exists.
// TESTING
//   1 Reset mid-RUN: assert rst_n=0 asynchronously
//     -> state=00, pc_en=0 and counters=0 immediately, with no clock edge.
//   2 start, then 5 cycles with halt_op=0, then halt_op=1
//     -> pc_en high for 5 cycles, 0 on the halt cycle; state=11;
//        instr_cnt=5, cycle_cnt=6; later start ignored; clear -> state=00, counters=0.
//   3 Three step pulses spaced 3 cycles apart from IDLE
//     -> exactly 3 single-cycle pc_en pulses; instr_cnt=3, cycle_cnt=3.
//   4 start and stop in the same cycle from IDLE -> stays IDLE.
//     stop during RUN -> pc_en=0 in the stop cycle, then IDLE.
//   5 CNT_W=4, RUN for 20 cycles -> instr_cnt and cycle_cnt saturate at 15.
//   6 (BREAKPOINT_EN) bp_addr=8'h04, bp_valid=1, pc counts 0,1,2...
//     -> pc_en=0 at pc=4, state=00, bp_hit=1; start -> pc=4 commits, bp_hit=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: gates instruction commit (PC load and write strobes),
// handles start/stop/step/HALT, and keeps saturating cycle/instruction counters.
// Optional breakpoint support is compiled in with `define RUN_CTRL_BREAKPOINT_EN.
module cpu_run_ctrl #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             clear,
    input  logic             halt_op,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             pc_en,
    output logic             wr_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_commit;
    logic             w_bp_stop;
    logic             w_active;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v == {CNT_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic r_skip_bp;
    logic r_bp_hit;

    assign w_bp_stop = bp_valid & (pc == bp_addr) & ~r_skip_bp;

    // Suppress the breakpoint for the first RUN cycle so a resume commits the breakpoint PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_bp <= 1'b0;
        end else if ((r_state != ST_RUN) && (w_next == ST_RUN)) begin
            r_skip_bp <= 1'b1;
        end else if (r_state == ST_RUN) begin
            r_skip_bp <= 1'b0;
        end else begin
            r_skip_bp <= r_skip_bp;
        end
    end

    // Sticky breakpoint flag: set when RUN stops on the breakpoint, cleared by start/step/clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp_hit <= 1'b0;
        end else if (clear) begin
            r_bp_hit <= 1'b0;
        end else if ((r_state == ST_RUN) && w_bp_stop && !halt_op && !stop) begin
            r_bp_hit <= 1'b1;
        end else if (start || step) begin
            r_bp_hit <= 1'b0;
        end else begin
            r_bp_hit <= r_bp_hit;
        end
    end

    assign bp_hit = r_bp_hit;
`else
    logic w_unused_bp;

    assign w_bp_stop   = 1'b0;
    assign bp_hit      = 1'b0;
    assign w_unused_bp = ^{bp_addr, bp_valid, pc};
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and commit decode; clear outranks everything, HALT outranks stop.
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear || stop) begin
                    w_next = ST_IDLE;
                end else if (start) begin
                    w_next = ST_RUN;
                end else if (step) begin
                    w_next = ST_STEP;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_commit = ~halt_op & ~stop & ~w_bp_stop & ~clear;
                if (clear) begin
                    w_next = ST_IDLE;
                end else if (halt_op) begin
                    w_next = ST_HALT;
                end else if (stop || w_bp_stop) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_STEP: begin
                w_commit = ~halt_op & ~clear;
                if (clear) begin
                    w_next = ST_IDLE;
                end else if (halt_op) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (clear) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_HALT;
                end
            end
            default: begin
                w_next   = ST_IDLE;
                w_commit = 1'b0;
            end
        endcase
    end

    assign w_active = (r_state == ST_RUN) || (r_state == ST_STEP);

    // Saturating counters; they hold outside RUN/STEP and only clear or reset zero them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= {CNT_W{1'b0}};
            r_instr_cnt <= {CNT_W{1'b0}};
        end else if (clear) begin
            r_cycle_cnt <= {CNT_W{1'b0}};
            r_instr_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_active) begin
                r_cycle_cnt <= sat_inc(r_cycle_cnt);
            end else begin
                r_cycle_cnt <= r_cycle_cnt;
            end
            if (w_commit) begin
                r_instr_cnt <= sat_inc(r_instr_cnt);
            end else begin
                r_instr_cnt <= r_instr_cnt;
            end
        end
    end

    assign pc_en     = w_commit;
    assign wr_en     = w_commit;
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed, table-driven bench for cpu_run_ctrl plus hand-written multi-cycle sequences;
// a second instance with CNT_W=4 exercises counter saturation.
module tb_cpu_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, step, stop, clear, halt_op;
    logic [7:0]  pc, bp_addr;
    logic        bp_valid;
    logic        pc_en, wr_en, bp_hit;
    logic [1:0]  state;
    logic [15:0] cycle_cnt, instr_cnt;
    logic        pc_en4, wr_en4, bp_hit4;
    logic [1:0]  state4;
    logic [3:0]  cycle_cnt4, instr_cnt4;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        st, sp, so, cl, ho;
        logic        en;
        logic [1:0]  s;
        logic [15:0] ic;
        logic [15:0] cc;
    } vec_t;

    vec_t vecs [0:39];
    int   nv;

    cpu_run_ctrl #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
        .clear(clear), .halt_op(halt_op), .pc(pc), .bp_addr(bp_addr),
        .bp_valid(bp_valid), .pc_en(pc_en), .wr_en(wr_en), .state(state),
        .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    cpu_run_ctrl #(.PC_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
        .clear(clear), .halt_op(halt_op), .pc(pc), .bp_addr(bp_addr),
        .bp_valid(bp_valid), .pc_en(pc_en4), .wr_en(wr_en4), .state(state4),
        .bp_hit(bp_hit4), .cycle_cnt(cycle_cnt4), .instr_cnt(instr_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic st, input logic sp, input logic so, input logic cl,
                        input logic ho, input logic en, input logic [1:0] s,
                        input logic [15:0] ic, input logic [15:0] cc);
        vecs[nv] = '{st, sp, so, cl, ho, en, s, ic, cc};
        nv++;
    endtask

    task automatic drive(input logic st, input logic sp, input logic so, input logic cl,
                         input logic ho);
        start = st; step = sp; stop = so; clear = cl; halt_op = ho;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        n_checks = 0; n_errors = 0; nv = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pc = 8'h00; bp_addr = 8'h00; bp_valid = 1'b0;

        // run/halt, priority, stop, clear-in-RUN, step cases
        addv(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b01, 16'd0, 16'd0);
        for (int k = 1; k <= 5; k++)
            addv(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b01, 16'(k), 16'(k));
        addv(1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0, 2'b11, 16'd5, 16'd6);
        addv(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b11, 16'd5, 16'd6);
        addv(1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0, 2'b11, 16'd5, 16'd6);
        addv(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        addv(1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        addv(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b01, 16'd0, 16'd0);
        addv(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b01, 16'd1, 16'd1);
        addv(1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0, 2'b00, 16'd1, 16'd2);
        addv(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b00, 16'd1, 16'd2);
        addv(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b01, 16'd1, 16'd2);
        addv(1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0, 2'b11, 16'd1, 16'd3);
        addv(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        addv(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0, 2'b01, 16'd0, 16'd0);
        addv(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b01, 16'd1, 16'd1);
        addv(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        addv(1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0, 2'b10, 16'd0, 16'd0);
        addv(1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0, 2'b11, 16'd0, 16'd1);
        addv(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        addv(1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        addv(1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0, 2'b01, 16'd0, 16'd0);
        addv(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 2'b00, 16'd0, 16'd0);
        addv(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0, 2'b10, 16'd0, 16'd0);
        addv(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1, 2'b00, 16'd1, 16'd1);
        addv(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0, 2'b00, 16'd0, 16'd0);

        #12;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_pc_en", 32'(pc_en), 32'd0);
        chk("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("reset_instr_cnt", 32'(instr_cnt), 32'd0);
        chk("reset_bp_hit", 32'(bp_hit), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].so, vecs[i].cl, vecs[i].ho);
            #1;
            chk($sformatf("vec%0d_pc_en", i), 32'(pc_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].en));
            tick();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].s));
            chk($sformatf("vec%0d_instr_cnt", i), 32'(instr_cnt), 32'(vecs[i].ic));
            chk($sformatf("vec%0d_cycle_cnt", i), 32'(cycle_cnt), 32'(vecs[i].cc));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of RUN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("pre_reset_cycle_cnt", 32'(cycle_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_pc_en", 32'(pc_en), 32'd0);
        chk("async_reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
        chk("async_reset_instr_cnt", 32'(instr_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_reset_state", 32'(state), 32'd0);

        // three step pulses spaced three cycles apart
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            step = (c == 0 || c == 3 || c == 6) ? 1'b1 : 1'b0;
            #1;
            if (pc_en) pulses++;
            if (wr_en !== pc_en) chk($sformatf("step_wr_en_c%0d", c), 32'(wr_en), 32'(pc_en));
            tick();
        end
        step = 1'b0;
        chk("step_pulses", 32'(pulses), 32'd3);
        chk("step_instr_cnt", 32'(instr_cnt), 32'd3);
        chk("step_cycle_cnt", 32'(cycle_cnt), 32'd3);
        chk("step_state", 32'(state), 32'd0);

        // saturation on the 4-bit instance
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("sat_cleared", 32'(cycle_cnt4), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        chk("sat_instr_cnt4", 32'(instr_cnt4), 32'd15);
        chk("sat_cycle_cnt4", 32'(cycle_cnt4), 32'd15);
        chk("run20_instr_cnt", 32'(instr_cnt), 32'd20);
        chk("run20_cycle_cnt", 32'(cycle_cnt), 32'd20);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("stop_pc_en", 32'(pc_en), 32'd0);
        tick();
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_instr_cnt", 32'(instr_cnt), 32'd20);

        // breakpoint at pc=4 while pc counts 0,1,2,...
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        bp_addr = 8'h04; bp_valid = 1'b1; pc = 8'h00;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            pc = 8'(k);
            #1;
            chk($sformatf("bp_run_pc%0d_pc_en", k), 32'(pc_en), 32'd1);
            tick();
        end
        pc = 8'h04;
        #1;
`ifdef RUN_CTRL_BREAKPOINT_EN
        chk("bp_stop_pc_en", 32'(pc_en), 32'd0);
        tick();
        chk("bp_stop_state", 32'(state), 32'd0);
        chk("bp_stop_bp_hit", 32'(bp_hit), 32'd1);
        chk("bp_stop_instr_cnt", 32'(instr_cnt), 32'd4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_resume_bp_hit", 32'(bp_hit), 32'd0);
        chk("bp_resume_state", 32'(state), 32'd1);
        #1;
        chk("bp_resume_pc_en", 32'(pc_en), 32'd1);
        tick();
        pc = 8'h05;
        #1;
        chk("bp_after_pc_en", 32'(pc_en), 32'd1);
        tick();
        chk("bp_after_instr_cnt", 32'(instr_cnt), 32'd6);
`else
        chk("nobp_pc_en", 32'(pc_en), 32'd1);
        tick();
        chk("nobp_state", 32'(state), 32'd1);
        chk("nobp_bp_hit", 32'(bp_hit), 32'd0);
        chk("nobp_instr_cnt", 32'(instr_cnt), 32'd5);
`endif
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("final_state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
